// File: rtl/mem_rw_sched_if.sv
// Burst request/data bundle shared by the requester side and the mem_burst_v2 side.
// The master modport drives requests and write data; the slave modport returns data and finish.
interface mem_rw_sched_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned DATA_W = 64
);
  logic              rd_burst_req;
  logic [LEN_W-1:0]  rd_burst_len;
  logic [ADDR_W-1:0] rd_burst_addr;
  logic              rd_burst_data_valid;
  logic [DATA_W-1:0] rd_burst_data;
  logic              rd_burst_finish;
  logic              wr_burst_req;
  logic [LEN_W-1:0]  wr_burst_len;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic              wr_burst_data_req;
  logic [DATA_W-1:0] wr_burst_data;
  logic              wr_burst_finish;

  modport master (
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output wr_burst_req, wr_burst_len, wr_burst_addr,
    input  wr_burst_data_req,
    output wr_burst_data,
    input  wr_burst_finish
  );

  modport slave (
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  wr_burst_req, wr_burst_len, wr_burst_addr,
    output wr_burst_data_req,
    input  wr_burst_data,
    output wr_burst_finish
  );
endinterface

// File: rtl/mem_rw_sched.sv
// Read/write time-sharing of the single mem_burst_v2 engine, one burst outstanding at a time.
// Optional busy watchdog is built in when MEM_RW_SCHED_WDT_EN is defined.
module mem_rw_sched #(
  parameter int unsigned ADDR_W        = 24,
  parameter int unsigned LEN_W         = 10,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned WR_STARVE_MAX = 4,
  parameter int unsigned WDT_CYCLES    = 4096
) (
  input  logic        mem_clk,
  input  logic        rst,
  input  logic        rd_urgent,
  mem_rw_sched_if.slave  s,
  mem_rw_sched_if.master m,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        wdt_err
);

  localparam int unsigned        StarveW   = $clog2(WR_STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(WR_STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StRdBusy, StWrBusy, StDone} state_e;

  state_e              state_q;
  logic [1:0]          grant_q;
  logic                busy_q;
  logic                last_wr_q;
  logic [StarveW-1:0]  starve_q;
  logic                rd_req_q, wr_req_q;
  logic [LEN_W-1:0]    rd_len_q, wr_len_q;
  logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
  logic                rd_fin_q, wr_fin_q;
  logic                pick_wr;
  logic [DATA_W-1:0]   rd_data, wr_data;

`ifdef MEM_RW_SCHED_WDT_EN
  localparam logic [12:0] WdtLast = 13'(WDT_CYCLES - 1);
  logic [12:0] wdt_cnt_q;
  logic        wdt_err_q;
`endif

  // Write wins when alone, when starved, or on its round-robin turn without urgency.
  always_comb begin
    pick_wr = 1'b0;
    if (s.wr_burst_req) begin
      if (!s.rd_burst_req)            pick_wr = 1'b1;
      else if (starve_q == StarveMax) pick_wr = 1'b1;
      else if (rd_urgent)             pick_wr = 1'b0;
      else                            pick_wr = ~last_wr_q;
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
      last_wr_q <= 1'b1;
      starve_q  <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_len_q  <= '0;
      wr_len_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_fin_q  <= 1'b0;
      wr_fin_q  <= 1'b0;
`ifdef MEM_RW_SCHED_WDT_EN
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
`endif
    end else begin
      rd_fin_q <= 1'b0;
      wr_fin_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_wr) begin
            state_q   <= StWrBusy;
            grant_q   <= 2'b10;
            busy_q    <= 1'b1;
            wr_len_q  <= s.wr_burst_len;
            wr_addr_q <= s.wr_burst_addr;
            last_wr_q <= 1'b1;
            starve_q  <= '0;
          end else if (s.rd_burst_req) begin
            state_q   <= StRdBusy;
            grant_q   <= 2'b01;
            busy_q    <= 1'b1;
            rd_len_q  <= s.rd_burst_len;
            rd_addr_q <= s.rd_burst_addr;
            last_wr_q <= 1'b0;
            if (s.wr_burst_req && starve_q != StarveMax) starve_q <= starve_q + StarveW'(1);
          end
        end
        // First busy cycle issues the request; a zero-length burst finishes without one.
        StRdBusy: begin
          if (!rd_req_q) begin
            if (rd_len_q == '0) begin
              rd_fin_q <= 1'b1;
              state_q  <= StDone;
            end else begin
              rd_req_q <= 1'b1;
            end
          end else if (m.rd_burst_finish) begin
            rd_req_q <= 1'b0;
            rd_fin_q <= 1'b1;
            state_q  <= StDone;
          end
        end
        StWrBusy: begin
          if (!wr_req_q) begin
            if (wr_len_q == '0) begin
              wr_fin_q <= 1'b1;
              state_q  <= StDone;
            end else begin
              wr_req_q <= 1'b1;
            end
          end else if (m.wr_burst_finish) begin
            wr_req_q <= 1'b0;
            wr_fin_q <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
`ifdef MEM_RW_SCHED_WDT_EN
      if (state_q == StRdBusy || state_q == StWrBusy) begin
        if (wdt_cnt_q == WdtLast) begin
          rd_req_q  <= 1'b0;
          wr_req_q  <= 1'b0;
          rd_fin_q  <= grant_q[0];
          wr_fin_q  <= grant_q[1];
          wdt_err_q <= 1'b1;
          wdt_cnt_q <= '0;
          state_q   <= StDone;
        end else begin
          wdt_cnt_q <= wdt_cnt_q + 13'd1;
        end
      end else begin
        wdt_cnt_q <= '0;
      end
`endif
    end
  end

  assign m.rd_burst_req   = rd_req_q;
  assign m.rd_burst_len   = rd_len_q;
  assign m.rd_burst_addr  = rd_addr_q;
  assign m.wr_burst_req   = wr_req_q;
  assign m.wr_burst_len   = wr_len_q;
  assign m.wr_burst_addr  = wr_addr_q;
  assign s.rd_burst_finish = rd_fin_q;
  assign s.wr_burst_finish = wr_fin_q;

  assign rd_data               = m.rd_burst_data;
  assign s.rd_burst_data       = rd_data;
  assign wr_data               = s.wr_burst_data;
  assign m.wr_burst_data       = wr_data;
  assign s.rd_burst_data_valid = m.rd_burst_data_valid & grant_q[0];
  assign s.wr_burst_data_req   = m.wr_burst_data_req & grant_q[1];

  assign busy  = busy_q;
  assign grant = grant_q;

`ifdef MEM_RW_SCHED_WDT_EN
  assign wdt_err = wdt_err_q;
`else
  // No watchdog in this build; WDT_CYCLES has no effect.
  assign wdt_err = 1'b0 & (WDT_CYCLES != 0);
`endif

endmodule
